mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative 32-bit multiply/divide execution stage. It sits directly downstream of the register-file read ports.
- Consumes the two read operands (A = rs value, B = rt value) and produces a 64-bit result. The multi-cycle control later writes this back through the write-data mux.
- Radix-2: shift-add multiply and restoring divide, one bit per clock. A start/busy/done handshake lets the control FSM stall while the unit runs.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 5, iteration-counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE or DONE.
- op  input  2  00 MULU, 01 DIVU, 10 MULS, 11 DIVS.
- opA  input  WIDTH  operand A: multiplicand or dividend.
- opB  input  WIDTH  operand B: multiplier or divisor.
- busy  output  1  high while iterating; control must hold.
- done  output  1  one-cycle pulse; results valid from this cycle.
- resultHi  output  WIDTH  product[63:32] or remainder.
- resultLo  output  WIDTH  product[31:0] or quotient.
- divByZero  output  1  set with done when a divide had opB==0.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is synchronous, active-high.
  - On rst: state=IDLE, busy=0, done=0, divByZero=0, resultHi=0, resultLo=0, counter=0.
  - rst wins over start in the same cycle. rst mid-RUN aborts the operation; no done pulse follows.
- State machine IDLE -> RUN -> DONE:
  - IDLE: start=1 captures op, opA and opB into internal registers and clears the counter. Next state is RUN, or DONE directly for divide-by-zero.
  - RUN: one iteration per cycle; counter increments. After iteration with counter==WIDTH-1, go to DONE.
  - DONE: done=1 for exactly one cycle, with result registers updated on entry. start=1 here is accepted (back-to-back, same as IDLE); otherwise go to IDLE.
- Latency and output timing:
  - start sampled at edge N. busy=1 for cycles N+1..N+WIDTH. done=1 in cycle N+WIDTH+1.
  - busy = (state==RUN). It is never high together with done.
  - start while in RUN is ignored; no queuing.
  - Result registers and divByZero hold their values until the next accepted start.
  - divByZero clears on the next accepted start.
- Multiply: 2*WIDTH accumulator. Each iteration: if multiplier LSB==1, add the multiplicand to the upper half; then shift right 1 with carry-in. Full 64-bit product, no overflow flag.
- Divide: restoring algorithm. Shift the remainder:dividend pair left by 1 and trial-subtract the divisor. If non-negative, keep the difference and set the quotient bit to 1; else restore and set it to 0. Quotient goes to resultLo, remainder to resultHi.
- Divide-by-zero (op[0]==1, opB==0): no iterations.
  - DONE is reached in cycle N+1.
  - resultLo=all ones, resultHi=opA, divByZero=1.
- Operand capture: operands are latched at start, so later changes on opA/opB do not affect the running operation.

Optional Feature:
- Macro: MUL_DIV_SIGNED_EN.
- Defined:
  - op 10/11 are signed (two's complement). Magnitudes are taken at capture and the core iterates unsigned.
  - Signs are applied on entry to DONE, with no extra cycle:
    - product sign = signA^signB;
    - quotient sign = signA^signB;
    - remainder sign = signA.
  - Overflow case 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0, divByZero=0.
- Not defined: op[1] is ignored, so 10 behaves as MULU and 11 as DIVU. No sign logic is synthesised.

Decomposition:
- Shared package (mul_div_pkg) holds:
  - op encodings MD_MULU/MD_DIVU/MD_MULS/MD_DIVS;
  - state enum MD_IDLE/MD_RUN/MD_DONE;
  - WIDTH default.
- One sub-module, md_datapath_step: combinational single iteration covering the add/shift for multiply and the subtract/restore for divide. The top block keeps the FSM, counter, operand capture and sign fix-up.

Test Plan:
- Reset mid-run:
  - Stimulus: MULU 7 x 6, assert rst at cycle N+10.
  - Response: busy=0 the next cycle, no done pulse, all outputs 0.
  - Then MULU 7 x 6 without reset: done at N+33, resultLo=42, resultHi=0.
- Full-width multiply:
  - Stimulus: MULU 0xFFFFFFFF x 0xFFFFFFFF.
  - Response: resultHi=0xFFFFFFFE, resultLo=0x00000001.
- Unsigned divide:
  - Stimulus: DIVU 100 / 7.
  - Response: resultLo=14, resultHi=2, divByZero=0, done exactly 33 cycles after start.
- Divide-by-zero:
  - Stimulus: DIVU 0x1234 / 0.
  - Response: done in cycle N+1, resultLo=0xFFFFFFFF, resultHi=0x1234, divByZero=1.
- Handshake:
  - Stimulus: start pulsed during RUN, then start asserted in the DONE cycle.
  - Response: the RUN-phase start is ignored; the DONE-phase start is accepted, and busy rises the next cycle.
- With MUL_DIV_SIGNED_EN:
  - Stimulus: DIVS -7 / 2, then MULS -3 x 5.
  - Response: quotient=0xFFFFFFFD and remainder=0xFFFFFFFF for the divide; product = 0xFFFFFFFF_FFFFFFF1 for the multiply.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mul_div_pkg;
   localparam int MD_WIDTH = 32;

   typedef enum logic [1:0] {
      MD_MULU = 2'b00,
      MD_DIVU = 2'b01,
      MD_MULS = 2'b10,
      MD_DIVS = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;
endpackage

// File: rtl/mul_div_if.sv
// Request/response bundle between the control FSM (master) and the mul/div unit (slave).
interface mul_div_if
   import mul_div_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] resultHi;
   logic [WIDTH-1:0] resultLo;
   logic             divByZero;

   modport master (output start, op, opA, opB,
                   input  busy, done, resultHi, resultLo, divByZero);
   modport slave  (input  start, op, opA, opB,
                   output busy, done, resultHi, resultLo, divByZero);
endinterface

// File: rtl/md_datapath_step.sv
// One radix-2 iteration: shift-add multiply or restoring-divide step; purely combinational.
module md_datapath_step #(
   parameter int WIDTH = 32
) (
   input  logic               i_is_div,
   input  logic [2*WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0]   i_opnd,
   output logic [2*WIDTH-1:0] o_acc
);
   logic [WIDTH-1:0] w_hi;
   logic [WIDTH-1:0] w_lo;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_trial;
   logic [WIDTH:0]   w_diff;

   always_comb begin
      w_hi    = i_acc[2*WIDTH-1:WIDTH];
      w_lo    = i_acc[WIDTH-1:0];
      w_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
      w_trial = {w_hi, w_lo[WIDTH-1]};
      w_diff  = w_trial - {1'b0, i_opnd};
      o_acc   = {w_sum, w_lo[WIDTH-1:1]};
      // remainder < divisor keeps the trial within WIDTH+1 bits, so bit WIDTH is the sign
      if (i_is_div) begin
         if (!w_diff[WIDTH]) o_acc = {w_diff[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b1};
         else                o_acc = {w_trial[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b0};
      end
   end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-bit mul/div, one bit per clock: done WIDTH+1 cycles after start (1 for div-by-zero).
// Signed ops 10/11 exist only with MUL_DIV_SIGNED_EN; start is ignored while busy.
module mul_div_unit
   import mul_div_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH,
   parameter int CNT_W = 5
) (
   input  logic     clk,
   input  logic     rst,
   mul_div_if.slave md_bus
);
   md_state_e          r_state;
   md_state_e          w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] w_step;
   logic [2*WIDTH-1:0] w_fixed;
   logic [WIDTH-1:0]   r_opnd;
   logic [WIDTH-1:0]   r_res_hi;
   logic [WIDTH-1:0]   r_res_lo;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic               r_is_div;
   logic               r_dbz;
   logic               w_accept;
   logic               w_div0;
   logic               w_last;

   assign w_accept = md_bus.start && (r_state == MD_IDLE || r_state == MD_DONE);
   assign w_div0   = md_bus.op[0] && (md_bus.opB == '0);
   assign w_last   = (r_cnt == CNT_W'(WIDTH-1));

`ifdef MUL_DIV_SIGNED_EN
   logic r_neg_q;
   logic r_neg_r;
   logic w_neg_a;
   logic w_neg_b;

   assign w_neg_a = md_bus.op[1] && md_bus.opA[WIDTH-1];
   assign w_neg_b = md_bus.op[1] && md_bus.opB[WIDTH-1];
   assign w_mag_a = w_neg_a ? (~md_bus.opA + 1'b1) : md_bus.opA;
   assign w_mag_b = w_neg_b ? (~md_bus.opB + 1'b1) : md_bus.opB;

   always_comb begin
      w_fixed = r_neg_q ? (~w_step + 1'b1) : w_step;
      if (r_is_div) begin
         w_fixed[2*WIDTH-1:WIDTH] = r_neg_r ? (~w_step[2*WIDTH-1:WIDTH] + 1'b1)
                                            : w_step[2*WIDTH-1:WIDTH];
         w_fixed[WIDTH-1:0]       = r_neg_q ? (~w_step[WIDTH-1:0] + 1'b1)
                                            : w_step[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (w_accept) begin
         r_neg_q <= w_neg_a ^ w_neg_b;
         r_neg_r <= w_neg_a;
      end
   end
`else
   logic w_unused_op1;

   assign w_unused_op1 = md_bus.op[1];
   assign w_mag_a      = md_bus.opA;
   assign w_mag_b      = md_bus.opB;
   assign w_fixed      = w_step;
`endif

   md_datapath_step #(.WIDTH(WIDTH)) u_step (
      .i_is_div (r_is_div),
      .i_acc    (r_acc),
      .i_opnd   (r_opnd),
      .o_acc    (w_step)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= MD_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         MD_IDLE: if (md_bus.start) w_next = w_div0 ? MD_DONE : MD_RUN;
         MD_RUN:  if (w_last) w_next = MD_DONE;
         MD_DONE: w_next = md_bus.start ? (w_div0 ? MD_DONE : MD_RUN) : MD_IDLE;
         default: w_next = MD_IDLE;
      endcase
   end

   always_comb begin
      md_bus.busy = (r_state == MD_RUN);
      md_bus.done = (r_state == MD_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_is_div <= 1'b0;
         r_dbz    <= 1'b0;
         r_res_hi <= '0;
         r_res_lo <= '0;
      end else if (w_accept) begin
         r_cnt    <= '0;
         r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
         r_opnd   <= w_mag_b;
         r_is_div <= md_bus.op[0];
         r_dbz    <= w_div0;
         if (w_div0) begin
            r_res_hi <= md_bus.opA;
            r_res_lo <= '1;
         end
      end else if (r_state == MD_RUN) begin
         r_acc <= w_step;
         r_cnt <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_res_hi <= w_fixed[2*WIDTH-1:WIDTH];
            r_res_lo <= w_fixed[WIDTH-1:0];
         end
      end
   end

   assign md_bus.resultHi  = r_res_hi;
   assign md_bus.resultLo  = r_res_lo;
   assign md_bus.divByZero = r_dbz;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit; expected values are hand-computed constants.
module tb_mul_div_unit;
   import mul_div_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   lat;
   int   done_seen;
   logic busy1;

   always #5 clk = ~clk;

   mul_div_if #(.WIDTH(32)) bus ();

   mul_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
      .clk    (clk),
      .rst    (rst),
      .md_bus (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Issues start now, scrambles operands after capture, returns cycles until done.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int poke, output int cyc, output logic b1);
      bus.op    = op;
      bus.opA   = a;
      bus.opB   = b;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.opA   = ~a;
      bus.opB   = b ^ 32'h5a5a_0001;
      b1        = bus.busy;
      cyc       = 1;
      while (!bus.done && cyc < 100) begin
         if (cyc == poke) begin
            bus.op    = MD_DIVU;
            bus.opA   = 32'd100;
            bus.opB   = 32'd3;
         end
         bus.start = (cyc == poke);
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         cyc++;
      end
      check("busy_with_done", {63'd0, bus.busy}, 64'd0);
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op    = MD_MULU;
      bus.opA   = '0;
      bus.opB   = '0;
      idle(2);
      check("rst_busy", {63'd0, bus.busy}, 64'd0);
      check("rst_done", {63'd0, bus.done}, 64'd0);
      check("rst_dbz",  {63'd0, bus.divByZero}, 64'd0);
      check("rst_hi",   {32'd0, bus.resultHi}, 64'd0);
      check("rst_lo",   {32'd0, bus.resultLo}, 64'd0);
      rst = 1'b0;
      idle(1);

      // reset while running aborts with no done pulse
      bus.op = MD_MULU; bus.opA = 32'd7; bus.opB = 32'd6; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      idle(9);
      check("abort_busy_before", {63'd0, bus.busy}, 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", {63'd0, bus.busy}, 64'd0);
      check("abort_done", {63'd0, bus.done}, 64'd0);
      check("abort_res",  {bus.resultHi, bus.resultLo}, 64'd0);
      check("abort_dbz",  {63'd0, bus.divByZero}, 64'd0);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) done_seen++;
         @(posedge clk); #1;
      end
      check("abort_no_done", 64'(done_seen), 64'd0);

      run_op(MD_MULU, 32'd7, 32'd6, -1, lat, busy1);
      check("mulu_lat",   64'(lat), 64'd33);
      check("mulu_busy1", {63'd0, busy1}, 64'd1);
      check("mulu_res",   {bus.resultHi, bus.resultLo}, 64'd42);
      idle(2);
      check("done_pulse", {63'd0, bus.done}, 64'd0);
      check("mulu_hold",  {bus.resultHi, bus.resultLo}, 64'd42);

      run_op(MD_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, lat, busy1);
      check("mulu_full", {bus.resultHi, bus.resultLo}, 64'hFFFF_FFFE_0000_0001);
      idle(1);
      run_op(MD_MULU, 32'h8000_0000, 32'd2, -1, lat, busy1);
      check("mulu_carry", {bus.resultHi, bus.resultLo}, 64'h0000_0001_0000_0000);
      idle(1);

      run_op(MD_DIVU, 32'h1234, 32'd0, -1, lat, busy1);
      check("div0_lat",   64'(lat), 64'd1);
      check("div0_busy1", {63'd0, busy1}, 64'd0);
      check("div0_res",   {bus.resultHi, bus.resultLo}, 64'h0000_1234_FFFF_FFFF);
      check("div0_flag",  {63'd0, bus.divByZero}, 64'd1);
      idle(1);

      run_op(MD_DIVU, 32'd100, 32'd7, -1, lat, busy1);
      check("divu_lat",  64'(lat), 64'd33);
      check("divu_res",  {bus.resultHi, bus.resultLo}, {32'd2, 32'd14});
      check("divu_dbz",  {63'd0, bus.divByZero}, 64'd0);
      idle(1);
      run_op(MD_DIVU, 32'd5, 32'd9, -1, lat, busy1);
      check("divu_small", {bus.resultHi, bus.resultLo}, {32'd5, 32'd0});
      idle(1);

      // start during RUN ignored; start in DONE accepted back-to-back
      run_op(MD_MULU, 32'd3, 32'd4, 5, lat, busy1);
      check("hs_lat", 64'(lat), 64'd33);
      check("hs_res", {bus.resultHi, bus.resultLo}, 64'd12);
      run_op(MD_DIVU, 32'd100, 32'd7, -1, lat, busy1);
      check("b2b_busy1", {63'd0, busy1}, 64'd1);
      check("b2b_lat",   64'(lat), 64'd33);
      check("b2b_res",   {bus.resultHi, bus.resultLo}, {32'd2, 32'd14});
      idle(1);

`ifdef MUL_DIV_SIGNED_EN
      run_op(MD_DIVS, 32'hFFFF_FFF9, 32'd2, -1, lat, busy1);
      check("divs_res", {bus.resultHi, bus.resultLo}, 64'hFFFF_FFFF_FFFF_FFFD);
      idle(1);
      run_op(MD_MULS, 32'hFFFF_FFFD, 32'd5, -1, lat, busy1);
      check("muls_res", {bus.resultHi, bus.resultLo}, 64'hFFFF_FFFF_FFFF_FFF1);
      idle(1);
      run_op(MD_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat, busy1);
      check("divs_ovf", {bus.resultHi, bus.resultLo}, 64'h0000_0000_8000_0000);
      check("divs_ovf_dbz", {63'd0, bus.divByZero}, 64'd0);
`else
      run_op(MD_DIVS, 32'hFFFF_FFF9, 32'd2, -1, lat, busy1);
      check("divs_as_u", {bus.resultHi, bus.resultLo}, 64'h0000_0001_7FFF_FFFC);
      idle(1);
      run_op(MD_MULS, 32'hFFFF_FFFD, 32'd5, -1, lat, busy1);
      check("muls_as_u", {bus.resultHi, bus.resultLo}, 64'h0000_0004_FFFF_FFF1);
      idle(1);
      run_op(MD_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat, busy1);
      check("divs_ovf_u", {bus.resultHi, bus.resultLo}, 64'h8000_0000_0000_0000);
      check("divs_ovf_u_dbz", {63'd0, bus.divByZero}, 64'd0);
`endif
      check("signed_lat", 64'(lat), 64'd33);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
